stump_control_mc: RTL
=====================

STUMP_CONTROL_MC -- requirements
Module: stump_control_mc

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: cycles that FETCH or MEMORY may wait on mem_ready before bus error (1..255).
REQ-002 SHALL have parameter CNT_W, default 8: width of the wait counter; TIMEOUT SHALL be less than 2^CNT_W.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ir  input  16  current instruction (Stump encoding).
REQ-006 cc  input  4  current flags {N,Z,V,C}.
REQ-007 mem_ready  input  1  memory completes the current access this cycle.
REQ-008 stall  input  1  freeze request from the debug/bus master.
REQ-009 fetch, execute, memory  output  1 each  one-hot state indicators.
REQ-010 halted  output  1  FSM is in HALT.
REQ-011 ir_en, pc_en  output  1 each  IR load enable and PC increment enable.
REQ-012 reg_write, cc_en  output  1 each  register-file write enable and flag update enable.
REQ-013 mem_ren, mem_wen  output  1 each  memory read and write strobes.
REQ-014 bus_err  output  1  sticky timeout error flag.
REQ-015 wait_cnt  output  CNT_W  current wait-cycle count.

Function
REQ-016 States: FETCH, EXECUTE, MEMORY, HALT; fetch/execute/memory/halted SHALL be a registered one-hot decode of the state.
REQ-017 FETCH: mem_ren=1; on mem_ready=1 assert ir_en=1 and pc_en=1 for that cycle, then go to EXECUTE; otherwise remain in FETCH.
REQ-018 EXECUTE, ALU ops (ir[15:13] 000-101): reg_write=1; cc_en=ir[11]; next state FETCH.
REQ-019 EXECUTE, LD/ST (ir[15:13]=110): no enables; next state MEMORY.
REQ-020 EXECUTE, Bcc (ir[15:13]=111): reg_write=1 only if the condition ir[11:8], evaluated on cc per the Stump Bcc table, is true; cc_en=0; next state FETCH.
REQ-021 MEMORY: ir[11]=0 (load) drives mem_ren=1 and reg_write=mem_ready; ir[11]=1 (store) drives mem_wen=1; on mem_ready=1 go to FETCH, otherwise remain.
REQ-022 wait_cnt: cleared on entry to FETCH/MEMORY and on mem_ready=1; increments each FETCH/MEMORY cycle with mem_ready=0; saturates at 2^CNT_W-1.
REQ-023 stall=1: state and wait_cnt SHALL hold, and every enable/strobe output SHALL be 0 that cycle.
REQ-024 stall=1 with mem_ready=1 in the same cycle: stall wins; mem_ready is ignored and the access is reissued.
REQ-025 HALT: all enables and strobes 0; state exits only by reset.
REQ-026 All enable and strobe outputs SHALL be combinational from the state and inputs; state and counter SHALL be registered.

Reset
REQ-027 With rst=0, asynchronously: state=FETCH (fetch=1, others 0), wait_cnt=0, bus_err=0.
REQ-028 During reset all strobes and enables SHALL be 0; mem_ren SHALL assert only after rst deasserts.
REQ-029 Reset mid-access SHALL abandon the access with no write strobe; the first post-reset cycle is FETCH.

Configuration
REQ-030 Macro STUMP_TIMEOUT_EN defined: when wait_cnt reaches TIMEOUT with mem_ready=0 and stall=0, the next state SHALL be HALT and bus_err SHALL set to 1 and stay set.
REQ-031 STUMP_TIMEOUT_EN undefined: HALT is unreachable, bus_err is tied to 0, and waits are unbounded (wait_cnt still counts and saturates).

Verification
REQ-032 Reset, mem_ready tied to 1, ir=16'h0000 (ADD, no S) -> FETCH/EXECUTE alternate; reg_write=1 and cc_en=0 in every EXECUTE.
REQ-033 ir=16'hC000 (LD) with mem_ready low for 3 MEMORY cycles -> memory held 4 cycles, reg_write=1 only in the 4th, then FETCH.
REQ-034 ir=16'hE000 (Bcc, always) -> reg_write=1; ir=16'hE100 (never) -> reg_write=0; cc_en=0 in both.
REQ-035 stall=1 for 2 cycles during FETCH with mem_ready=1 -> no ir_en or pc_en in those cycles; ir_en fires on the first cycle after stall drops.
REQ-036 STUMP_TIMEOUT_EN defined, TIMEOUT=4, mem_ready=0 in FETCH -> HALT after the 5th wait cycle with bus_err=1, held until rst=0; macro undefined -> FETCH holds indefinitely and wait_cnt saturates at 255.

Source files
------------

// File: rtl/stump_control_mc.sv
// stump_control_mc: multi-cycle control FSM for the Stump processor.
//
// The FSM walks FETCH -> EXECUTE -> (MEMORY) -> FETCH. HALT is entered only
// when the optional bus timeout is compiled in.
//
// Ports:
//   clk_i        system clock; all state changes on its rising edge
//   rst_ni       asynchronous active-low reset
//   ir_i         current instruction (Stump encoding)
//   cc_i         current flags {N,Z,V,C}
//   mem_ready_i  memory completes the current access this cycle
//   stall_i      freeze request from the debug/bus master
//   fetch_o, execute_o, memory_o, halted_o   one-hot state indicators
//   ir_en_o, pc_en_o        IR load enable, PC increment enable
//   reg_write_o, cc_en_o    register-file write enable, flag update enable
//   mem_ren_o, mem_wen_o    memory read and write strobes
//   bus_err_o               sticky timeout error flag
//   wait_cnt_o              current wait-cycle count (saturating)
//
// Build option: define STUMP_TIMEOUT_EN to enable the memory-wait timeout,
// which moves the FSM to HALT and sets bus_err_o. Without it HALT is
// unreachable, bus_err_o is 0 and waits are unbounded.
// TIMEOUT must be in 1..255 and below 2**CNT_W.

module stump_control_mc #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [15:0]      ir_i,
    input  logic [3:0]       cc_i,
    input  logic             mem_ready_i,
    input  logic             stall_i,
    output logic             fetch_o,
    output logic             execute_o,
    output logic             memory_o,
    output logic             halted_o,
    output logic             ir_en_o,
    output logic             pc_en_o,
    output logic             reg_write_o,
    output logic             cc_en_o,
    output logic             mem_ren_o,
    output logic             mem_wen_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] wait_cnt_o
);

    typedef enum logic [1:0] {StFetch, StExecute, StMemory, StHalt} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout;
    logic             cond_true;
    logic             is_ldst, is_bcc;
    logic             flag_n, flag_z, flag_v, flag_c;

    // Only opcode, S/cond and store bits steer the controller.
    logic unused_ir;
    assign unused_ir = ^{ir_i[12], ir_i[7:0]};

    assign is_ldst = (ir_i[15:13] == 3'b110);
    assign is_bcc  = (ir_i[15:13] == 3'b111);
    assign {flag_n, flag_z, flag_v, flag_c} = cc_i;

    // Bcc condition table, ir[11:8].
    always_comb begin
        cond_true = 1'b0;
        unique case (ir_i[11:8])
            4'h0: cond_true = 1'b1;                          // BAL
            4'h1: cond_true = 1'b0;                          // BNV
            4'h2: cond_true = !flag_c && !flag_z;            // BHI
            4'h3: cond_true = flag_c || flag_z;              // BLS
            4'h4: cond_true = !flag_c;                       // BCC
            4'h5: cond_true = flag_c;                        // BCS
            4'h6: cond_true = !flag_z;                       // BNE
            4'h7: cond_true = flag_z;                        // BEQ
            4'h8: cond_true = !flag_v;                       // BVC
            4'h9: cond_true = flag_v;                        // BVS
            4'ha: cond_true = !flag_n;                       // BPL
            4'hb: cond_true = flag_n;                        // BMI
            4'hc: cond_true = !(flag_n ^ flag_v);            // BGE
            4'hd: cond_true = flag_n ^ flag_v;               // BLT
            4'he: cond_true = !((flag_n ^ flag_v) || flag_z); // BGT
            4'hf: cond_true = (flag_n ^ flag_v) || flag_z;   // BLE
            default: cond_true = 1'b0;
        endcase
    end

`ifdef STUMP_TIMEOUT_EN
    assign timeout = !mem_ready_i && (wait_cnt_q >= CNT_W'(TIMEOUT));
`else
    assign timeout = 1'b0;
`endif

    // State and wait counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StFetch;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next state. A stall freezes everything, including a same-cycle mem_ready.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (!stall_i) begin
            unique case (state_q)
                StFetch, StMemory: begin
                    if (mem_ready_i) begin
                        state_d    = (state_q == StFetch) ? StExecute : StFetch;
                        wait_cnt_d = '0;
                    end else if (timeout) begin
                        state_d = StHalt;
                    end else if (wait_cnt_q != '1) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                StExecute: begin
                    state_d    = is_ldst ? StMemory : StFetch;
                    wait_cnt_d = '0;
                end
                StHalt: state_d = StHalt;
                default: state_d = StFetch;
            endcase
        end
    end

    // Strobes and enables: combinational, forced low in reset, stall and HALT.
    always_comb begin
        ir_en_o     = 1'b0;
        pc_en_o     = 1'b0;
        reg_write_o = 1'b0;
        cc_en_o     = 1'b0;
        mem_ren_o   = 1'b0;
        mem_wen_o   = 1'b0;
        if (rst_ni && !stall_i) begin
            unique case (state_q)
                StFetch: begin
                    mem_ren_o = 1'b1;
                    ir_en_o   = mem_ready_i;
                    pc_en_o   = mem_ready_i;
                end
                StExecute: begin
                    if (is_bcc) begin
                        reg_write_o = cond_true;
                    end else if (!is_ldst) begin
                        reg_write_o = 1'b1;
                        cc_en_o     = ir_i[11];
                    end
                end
                StMemory: begin
                    if (ir_i[11]) begin
                        mem_wen_o = 1'b1;
                    end else begin
                        mem_ren_o   = 1'b1;
                        reg_write_o = mem_ready_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fetch_o    = (state_q == StFetch);
    assign execute_o  = (state_q == StExecute);
    assign memory_o   = (state_q == StMemory);
    assign halted_o   = (state_q == StHalt);
    assign wait_cnt_o = wait_cnt_q;

`ifdef STUMP_TIMEOUT_EN
    logic bus_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus_err_q <= 1'b0;
        end else if (state_d == StHalt) begin
            bus_err_q <= 1'b1;
        end
    end

    assign bus_err_o = bus_err_q;
`else
    assign bus_err_o = 1'b0;
`endif

endmodule
